fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Single-clock round-robin arbiter that shares the write port of the 16-entry, 8-bit FIFO among `NREQ` producers in the write clock domain. It grants one producer at a time for a bounded burst and drives `wren`/`wrdata` into the FIFO. It stalls on FIFO `full` and acknowledges every accepted beat back to the owning producer.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `DW`, default 8: data width; matches the FIFO `wrdata` width.
- `MAX_BURST`, default 4: maximum beats per grant, range 1..16.
- `wrclk  in  1`: write-domain clock. This is the block's only clock.
- `rst  in  1`: synchronous, active-high reset, sampled on the rising edge of `wrclk`.
- `req  in  NREQ`: per-requester request. The requester holds it high until its final beat is acked.
- `req_data  in  NREQ*DW`: requester i's data, in bits `[i*DW +: DW]`. The requester holds it stable until acked.
- `req_last  in  NREQ`: marks the current beat as the last of the requester's packet.
- `full  in  1`: FIFO full flag, sampled combinationally.
- `gnt  out  NREQ`: one-hot registered grant, or all zero.
- `ack  out  NREQ`: one-hot, high in the cycle the owner's beat is written.
- `wren  out  1`: FIFO write enable.
- `wrdata  out  DW`: FIFO write data.
- `busy  out  1`: high while in state BURST.
- `stat_beats  out  NREQ*16`: per-requester accepted-beat counters (see Configuration).
- `stat_stalls  out  16`: count of cycles stalled on `full` (see Configuration).

## Operation
- **States:** IDLE and BURST. Registered state is `state`, `owner`, `last_owner` and `beat_cnt` (4 bits).
- **IDLE:**
  - With `req` all zero, the block stays in IDLE.
  - Otherwise it picks the first set `req` bit scanning upward from `last_owner+1`, modulo `NREQ`.
  - On the next edge it moves to BURST with `owner` set to the pick, `gnt[owner]`=1 and `beat_cnt`=0.
- **Beat in BURST:** a beat occurs when `req[owner]` & ~`full`.
  - Combinationally: `wren`=1, `wrdata`=`req_data[owner]`, `ack[owner]`=1.
  - At the edge, `beat_cnt` is incremented.
- **Release from BURST:** the block releases at the edge of either of these cycles:
  - a beat with `req_last[owner]`=1, or a beat with `beat_cnt`==`MAX_BURST`-1;
  - a cycle with `req[owner]`=0 (withdrawal; no write that cycle).
- **Effect of release:** `last_owner`<=`owner`, `gnt`<=0, state<=IDLE.
- **`full` stall:** `wren`=0, `ack`=0, `beat_cnt` held. There is no timeout, and the grant is kept indefinitely.
- **Non-owners:** never receive `ack` and are never reflected on `wrdata`.
- **`wrdata` when `wren`=0:** drives `req_data[owner]` in BURST and 0 in IDLE. The value is don't-care for the FIFO.
- **Fairness:** every requester holding `req` is granted within `NREQ`-1 intervening bursts.
- **Reset values:**
  - Registers: state=IDLE, `owner`=0, `last_owner`=`NREQ`-1 (requester 0 wins first), `beat_cnt`=0.
  - Outputs: `gnt`=0, `ack`=0, `wren`=0, `wrdata`=0, `busy`=0, `stat_*`=0.
- **Reset mid-burst:** the grant is dropped immediately and the unacked beat is not written. The producer keeps holding `req` and is re-arbitrated after reset.

## Timing
- **Arbitration latency:** `req` rising in an IDLE cycle gives `gnt` high the next cycle. The first `ack`/`wren` can occur in that same cycle.
- **Throughput:** one beat per cycle within a burst.
- **Gap between bursts:** exactly one IDLE cycle.
- **Combinational path:** `wren`/`ack`/`wrdata` depend combinationally on `full`, `req[owner]` and `req_data[owner]`. All other outputs are registered.
- **Counters:** `beat_cnt` never exceeds `MAX_BURST`-1 at an edge. Width arithmetic is 4-bit unsigned.

## Configuration
- Macro: `FIFO_ARB_STATS_EN`.
- **Defined:**
  - `stat_beats[i]` increments on every `ack[i]`.
  - `stat_stalls` increments on every BURST cycle with `req[owner]` & `full`.
  - Both are 16-bit, saturating at 16'hFFFF, and cleared by `rst`.
- **Undefined:** the ports remain present and are tied to 0, and no counter flops are synthesized.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state enum (IDLE, BURST);
  - the owner-index width `$clog2(NREQ)` as a function, plus the `MAX_BURST` limit constant;
  - `STAT_W`=16.
- One sub-module, `rr_pick`: a combinational round-robin picker.
  - Inputs: request vector and `last_owner`.
  - Outputs: `valid` and index.

## Test plan
- **Basic write:** reset, then `req`=4'b0001 with `req_last`=1 and data 8'hA5. Expect `gnt[0]` one cycle later, `wren`=1, `wrdata`=8'hA5, `ack[0]` for one cycle, then IDLE.
- **Round robin:** `req`=4'b1111 held, all packets 1 beat. Expect grant order 0,1,2,3,0 with one IDLE cycle between grants.
- **Burst cap:** `MAX_BURST`=4, requester 2 streams 10 beats without `req_last`, requester 3 also requesting. Expect 4 beats from 2, then 4 from 3, then 4 more from 2.
- **Full stall:** `full`=1 for 5 cycles mid-burst. Expect `wren`=`ack`=0 and `gnt` held, then beats resume. With `FIFO_ARB_STATS_EN`, `stat_stalls` increases by 5.
- **Withdrawal:** owner drops `req` after 1 beat. Expect release at that edge, no `ack`, and the next requester granted.
- **Reset mid-burst:** `rst` during beat 2 of 4. Expect all outputs 0 the next cycle, then requester 0 granted first after reset.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Upper bound on MAX_BURST: beat_cnt is 4 bits wide.
  localparam int unsigned MAX_BURST_LIMIT = 16;

  localparam int unsigned STAT_W = 16;

  // Owner index width; never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward
// from last_owner+1, wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_owner,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  int unsigned cand;

  // Scan from last_owner+1 upward; the first hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(last_owner) + k) % NREQ;
      if (!valid && req[IW'(cand)]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NREQ producers.
// Optional statistics counters are enabled with FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                   wrclk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DW-1:0]     req_data,
  input  logic [NREQ-1:0]        req_last,
  input  logic                   full,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  output logic                   wren,
  output logic [DW-1:0]          wrdata,
  output logic                   busy,
  output logic [NREQ*STAT_W-1:0] stat_beats,
  output logic [STAT_W-1:0]      stat_stalls
);

  localparam int unsigned IW = idx_w(NREQ);

  state_t          state, state_d;
  logic [IW-1:0]   owner, owner_d;
  logic [IW-1:0]   last_owner, last_owner_d;
  logic [3:0]      beat_cnt, beat_cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;

  logic                     pick_valid;
  logic [IW-1:0]            pick_idx;
  logic [NREQ-1:0][DW-1:0]  data_arr;
  logic [NREQ-1:0]          owner_oh;
  logic                     beat;
  logic                     stall;
  logic                     release_now;

  assign data_arr = req_data;
  assign owner_oh = NREQ'(1) << owner;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  // Beat/stall qualification and FIFO-side outputs; reset suppresses the
  // in-flight beat so nothing is written during the reset cycle.
  always_comb begin
    beat   = (state == BURST) && req[owner] && !full && !rst;
    stall  = (state == BURST) && req[owner] && full;
    wren   = beat;
    ack    = beat ? owner_oh : '0;
    wrdata = (state == BURST) ? data_arr[owner] : '0;
    release_now = (state == BURST) &&
                  (!req[owner] ||
                   (beat && (req_last[owner] || beat_cnt == 4'(MAX_BURST - 1))));
  end

  // Next-state logic for state, owner, last_owner, beat_cnt and grant.
  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_owner_d = last_owner;
    beat_cnt_d   = beat_cnt;
    gnt_d        = gnt_q;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_d    = BURST;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          gnt_d      = NREQ'(1) << pick_idx;
        end
      end
      BURST: begin
        if (release_now) begin
          state_d      = IDLE;
          last_owner_d = owner;
          gnt_d        = '0;
        end else if (beat) begin
          beat_cnt_d = beat_cnt + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered arbiter state.
  always_ff @(posedge wrclk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IW'(NREQ - 1);
      beat_cnt   <= '0;
      gnt_q      <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_owner <= last_owner_d;
      beat_cnt   <= beat_cnt_d;
      gnt_q      <= gnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state == BURST);

`ifdef FIFO_ARB_STATS_EN
  logic [NREQ-1:0][STAT_W-1:0] beats_q;
  logic [STAT_W-1:0]           stalls_q;

  for (genvar i = 0; i < NREQ; i++) begin : g_beats
    // Saturating per-requester accepted-beat counter.
    always_ff @(posedge wrclk) begin
      if (rst) begin
        beats_q[i] <= '0;
      end else if (ack[i] && beats_q[i] != '1) begin
        beats_q[i] <= beats_q[i] + 1'b1;
      end
    end
  end

  // Saturating count of cycles the owner was blocked by full.
  always_ff @(posedge wrclk) begin
    if (rst) begin
      stalls_q <= '0;
    end else if (stall && stalls_q != '1) begin
      stalls_q <= stalls_q + 1'b1;
    end
  end

  assign stat_beats  = beats_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_beats  = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, DW=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  logic        wrclk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic        full;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        wren;
  logic [7:0]  wrdata;
  logic        busy;
  logic [63:0] stat_beats;
  logic [15:0] stat_stalls;

  int vectors = 0;
  int errors  = 0;

  fifo_wr_arbiter #(
    .NREQ      (4),
    .DW        (8),
    .MAX_BURST (4)
  ) dut (
    .wrclk       (wrclk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .req_last    (req_last),
    .full        (full),
    .gnt         (gnt),
    .ack         (ack),
    .wren        (wren),
    .wrdata      (wrdata),
    .busy        (busy),
    .stat_beats  (stat_beats),
    .stat_stalls (stat_stalls)
  );

  initial wrclk = 1'b0;
  always #5 wrclk = ~wrclk;

  task automatic tick;
    @(posedge wrclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  int        seq [14] = '{2, 2, 2, 2, -1, 3, 3, 3, 3, -1, 2, 2, 2, 2};
  int        e;
  logic [3:0] oh;

  initial begin
    rst = 1'b1; req = '0; req_data = '0; req_last = '0; full = 1'b0;
    tick; tick;

    // Reset state
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wren", 32'(wren), 0);
    chk("rst_wrdata", 32'(wrdata), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_beats_lo", stat_beats[31:0], 0);
    chk("rst_beats_hi", stat_beats[63:32], 0);
    chk("rst_stalls", 32'(stat_stalls), 0);

    // Basic write
    rst = 1'b0; req = 4'b0001; req_last = 4'b0001; req_data = 32'h0000_00A5;
    #1;
    chk("basic_latency_gnt", 32'(gnt), 0);
    chk("basic_latency_wren", 32'(wren), 0);
    tick;
    chk("basic_gnt", 32'(gnt), 32'h1);
    chk("basic_busy", 32'(busy), 1);
    chk("basic_wren", 32'(wren), 1);
    chk("basic_wrdata", 32'(wrdata), 32'hA5);
    chk("basic_ack", 32'(ack), 32'h1);
    tick;
    req = '0; req_last = '0;
    #1;
    chk("basic_idle_gnt", 32'(gnt), 0);
    chk("basic_idle_busy", 32'(busy), 0);
    chk("basic_idle_wrdata", 32'(wrdata), 0);

    // Round robin from reset: 0,1,2,3,0 with one idle cycle between
    rst = 1'b1;
    tick;
    rst = 1'b0; req = 4'hF; req_last = 4'hF; req_data = 32'h1312_1110;
    #1;
    chk("rr_start_gnt", 32'(gnt), 0);
    for (int k = 0; k < 5; k++) begin
      e  = k % 4;
      oh = 4'(1 << e);
      tick;
      chk("rr_gnt", 32'(gnt), 32'(oh));
      chk("rr_wrdata", 32'(wrdata), 32'h10 + 32'(e));
      chk("rr_ack", 32'(ack), 32'(oh));
      tick;
      chk("rr_gap_gnt", 32'(gnt), 0);
    end
    req = '0;

    // Burst cap: requesters 2 and 3, no req_last
    req_last = '0; req = 4'b1100; req_data = 32'h3322_0000;
    for (int k = 0; k < 14; k++) begin
      tick;
      e = seq[k];
      if (e < 0) begin
        chk("cap_gap_gnt", 32'(gnt), 0);
        chk("cap_gap_wren", 32'(wren), 0);
      end else begin
        oh = 4'(1 << e);
        chk("cap_gnt", 32'(gnt), 32'(oh));
        chk("cap_wren", 32'(wren), 1);
        chk("cap_wrdata", 32'(wrdata), (e == 2) ? 32'h22 : 32'h33);
      end
    end
    tick;
    req = '0;
    #1;
    chk("cap_end_busy", 32'(busy), 0);

    // Full stall: owner 0, 5 stalled cycles after its first beat
    req = 4'b0001; req_data = 32'h0000_005A;
    tick;
    chk("stall_first_wren", 32'(wren), 1);
    tick;
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick;
      #1;
      chk("stall_wren", 32'(wren), 0);
      chk("stall_ack", 32'(ack), 0);
      chk("stall_gnt", 32'(gnt), 32'h1);
    end
    tick;
    full = 1'b0;
    #1;
    chk("resume_wren", 32'(wren), 1);
    chk("resume_ack", 32'(ack), 32'h1);
    chk("resume_wrdata", 32'(wrdata), 32'h5A);
    tick;
    chk("resume_beat3_wren", 32'(wren), 1);
    tick;
    chk("resume_beat4_wren", 32'(wren), 1);
    tick;
    req = '0;
    #1;
    chk("stall_end_gnt", 32'(gnt), 0);
`ifdef FIFO_ARB_STATS_EN
    chk("stat_stalls", 32'(stat_stalls), 5);
    chk("stat_beats_lo", stat_beats[31:0], 32'h0001_0006);
    chk("stat_beats_hi", stat_beats[63:32], 32'h0005_0009);
`else
    chk("stat_stalls_tied", 32'(stat_stalls), 0);
    chk("stat_beats_tied", stat_beats[31:0] | stat_beats[63:32], 0);
`endif

    // Withdrawal: owner 1 drops req after one beat, then owner 2
    req = 4'b0110; req_data = 32'h0022_1100;
    tick;
    chk("wd_gnt1", 32'(gnt), 32'h2);
    chk("wd_ack1", 32'(ack), 32'h2);
    chk("wd_wrdata1", 32'(wrdata), 32'h11);
    tick;
    req = 4'b0100;
    #1;
    chk("wd_drop_wren", 32'(wren), 0);
    chk("wd_drop_ack", 32'(ack), 0);
    chk("wd_drop_gnt", 32'(gnt), 32'h2);
    tick;
    chk("wd_idle_gnt", 32'(gnt), 0);
    tick;
    chk("wd_gnt2", 32'(gnt), 32'h4);
    chk("wd_ack2", 32'(ack), 32'h4);
    chk("wd_wrdata2", 32'(wrdata), 32'h22);
    tick;
    req = '0;
    #1;
    chk("wd2_drop_wren", 32'(wren), 0);
    tick;
    chk("wd2_idle_gnt", 32'(gnt), 0);

    // Reset mid-burst: owner 3 reset during beat 2, then 0 wins
    req = 4'b1011; req_data = 32'h7700_0044;
    tick;
    chk("rmb_gnt", 32'(gnt), 32'h8);
    chk("rmb_wrdata", 32'(wrdata), 32'h77);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("rmb_gnt0", 32'(gnt), 0);
    chk("rmb_ack0", 32'(ack), 0);
    chk("rmb_wren0", 32'(wren), 0);
    chk("rmb_wrdata0", 32'(wrdata), 0);
    chk("rmb_busy0", 32'(busy), 0);
    chk("rmb_stalls0", 32'(stat_stalls), 0);
    tick;
    chk("rmb_regnt", 32'(gnt), 32'h1);
    chk("rmb_reack", 32'(ack), 32'h1);
    chk("rmb_rewrdata", 32'(wrdata), 32'h44);
    req = '0;
    tick; tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
